// File: rtl/npg_multich_env_pkg.sv
// Shared types and constants for the multichannel pulse generator:
// envelope state encoding, envelope scale and sequencer phases.
package npg_pkg;

  localparam int ENV_W    = 9;
  localparam int ENV_FULL = 256;

  typedef enum logic [2:0] {
    ENV_IDLE = 3'b000,
    ENV_UP   = 3'b001,
    ENV_ON   = 3'b011,
    ENV_DOWN = 3'b010,
    ENV_OFF  = 3'b110
  } env_state_t;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_PH1,
    SEQ_GAP,
    SEQ_PH2
  } seq_state_t;

  function automatic env_state_t env_successor(input env_state_t s);
    env_state_t n;
    case (s)
      ENV_UP:   n = ENV_ON;
      ENV_ON:   n = ENV_DOWN;
      ENV_DOWN: n = ENV_OFF;
      default:  n = ENV_UP;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/npg_multich_env_if.sv
// Configuration-in / drive-out bundle between the register bank (master)
// and the pulse generator (slave).
interface npg_multich_env_if #(
  parameter int N_ELEC = 4,
  parameter int FREQ_W = 12,
  parameter int PW_W   = 3,
  parameter int GAP_W  = 2,
  parameter int AMP_W  = 6,
  parameter int RAMP_W = 6,
  parameter int ON_W   = 8,
  parameter int OFF_W  = 10
);
  logic              enable;
  logic [FREQ_W-1:0] freq;
  logic [PW_W-1:0]   phase_dur;
  logic [GAP_W-1:0]  gap;
  logic [AMP_W-1:0]  amplitude;
  logic [RAMP_W-1:0] ramp;
  logic [7:0]        ramp_factor;
  logic [ON_W-1:0]   on_time;
  logic [OFF_W-1:0]  off_time;
  logic [N_ELEC-1:0] electrode1;
  logic [N_ELEC-1:0] electrode2;
  logic [N_ELEC-1:0] up_switches;
  logic [N_ELEC-1:0] down_switches;
  logic [AMP_W-1:0]  amp_out;
  logic [2:0]        env_state;
  logic              pulse_start;

  modport master (
    output enable, freq, phase_dur, gap, amplitude, ramp, ramp_factor,
           on_time, off_time, electrode1, electrode2,
    input  up_switches, down_switches, amp_out, env_state, pulse_start
  );

  modport slave (
    input  enable, freq, phase_dur, gap, amplitude, ramp, ramp_factor,
           on_time, off_time, electrode1, electrode2,
    output up_switches, down_switches, amp_out, env_state, pulse_start
  );
endinterface

// File: rtl/npg_biphase_seq.sv
// Biphasic pulse sequencer: phase 1, optional gap, mirrored phase 2,
// with all pulse parameters snapshotted on the start strobe.
module npg_biphase_seq
  import npg_pkg::*;
#(
  parameter int N_ELEC = 4,
  parameter int PW_W   = 3,
  parameter int GAP_W  = 2,
  parameter int AMP_W  = 6
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              abort,
  input  logic              start,
  input  logic [PW_W-1:0]   phase_dur,
  input  logic [GAP_W-1:0]  gap,
  input  logic [AMP_W-1:0]  amplitude,
  input  logic [N_ELEC-1:0] electrode1,
  input  logic [N_ELEC-1:0] electrode2,
  output logic              busy,
  output logic [N_ELEC-1:0] up_switches,
  output logic [N_ELEC-1:0] down_switches,
  output logic [AMP_W-1:0]  amp_out,
  output logic              pulse_start
);
  localparam int CW = (PW_W > GAP_W) ? PW_W : GAP_W;

  seq_state_t        state_reg;
  logic [CW-1:0]     cnt_reg;
  logic [PW_W-1:0]   pw_reg;
  logic [GAP_W-1:0]  gap_reg;
  logic [N_ELEC-1:0] anode_reg;
  logic [N_ELEC-1:0] cathode_reg;
  logic [N_ELEC-1:0] up_reg;
  logic [N_ELEC-1:0] down_reg;
  logic [AMP_W-1:0]  amp_reg;
  logic              start_reg;
  logic [N_ELEC-1:0] anode_mask;
  logic [N_ELEC-1:0] cathode_mask;

  // Electrodes claimed by both sides are dropped so no bridge leg shorts.
  assign anode_mask   = electrode1 & ~electrode2;
  assign cathode_mask = electrode2 & ~electrode1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= SEQ_IDLE;
      cnt_reg     <= '0;
      pw_reg      <= '0;
      gap_reg     <= '0;
      anode_reg   <= '0;
      cathode_reg <= '0;
      up_reg      <= '0;
      down_reg    <= '0;
      amp_reg     <= '0;
      start_reg   <= 1'b0;
    end else if (abort) begin
      state_reg <= SEQ_IDLE;
      cnt_reg   <= '0;
      up_reg    <= '0;
      down_reg  <= '0;
      amp_reg   <= '0;
      start_reg <= 1'b0;
    end else begin
      start_reg <= 1'b0;
      case (state_reg)
        SEQ_IDLE: if (start) begin
          pw_reg      <= phase_dur;
          gap_reg     <= gap;
          anode_reg   <= anode_mask;
          cathode_reg <= cathode_mask;
          cnt_reg     <= CW'(phase_dur) - 1'b1;
          up_reg      <= anode_mask;
          down_reg    <= cathode_mask;
          amp_reg     <= amplitude;
          start_reg   <= 1'b1;
          state_reg   <= SEQ_PH1;
        end
        SEQ_PH1: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else if (gap_reg != '0) begin
            state_reg <= SEQ_GAP;
            cnt_reg   <= CW'(gap_reg) - 1'b1;
            up_reg    <= '0;
            down_reg  <= '0;
          end else begin
            state_reg <= SEQ_PH2;
            cnt_reg   <= CW'(pw_reg) - 1'b1;
            up_reg    <= cathode_reg;
            down_reg  <= anode_reg;
          end
        end
        SEQ_GAP: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else begin
            state_reg <= SEQ_PH2;
            cnt_reg   <= CW'(pw_reg) - 1'b1;
            up_reg    <= cathode_reg;
            down_reg  <= anode_reg;
          end
        end
        default: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else begin
            state_reg <= SEQ_IDLE;
            up_reg    <= '0;
            down_reg  <= '0;
            amp_reg   <= '0;
          end
        end
      endcase
    end
  end

  assign busy          = (state_reg != SEQ_IDLE);
  assign up_switches   = up_reg;
  assign down_switches = down_reg;
  assign amp_out       = amp_reg;
  assign pulse_start   = start_reg;
endmodule

// File: rtl/npg_multich_env.sv
// Pulse generator top: period counter, UP/ON/DOWN/OFF envelope FSM and
// amplitude scaling feeding the biphasic sequencer.
module npg_multich_env
  import npg_pkg::*;
#(
  parameter int N_ELEC = 4,
  parameter int FREQ_W = 12,
  parameter int PW_W   = 3,
  parameter int GAP_W  = 2,
  parameter int AMP_W  = 6,
  parameter int RAMP_W = 6,
  parameter int ON_W   = 8,
  parameter int OFF_W  = 10
) (
  input logic              clk,
  input logic              resetn,
  npg_multich_env_if.slave bus
);
  localparam int CNT_W = (OFF_W > ON_W) ? ((OFF_W > RAMP_W) ? OFF_W : RAMP_W)
                                        : ((ON_W > RAMP_W) ? ON_W : RAMP_W);
  localparam logic [ENV_W:0] FULL_X = ENV_FULL;

  env_state_t              state_reg;
  logic [FREQ_W-1:0]       count_reg;
  logic [FREQ_W-1:0]       freq_reg;
  logic [CNT_W-1:0]        len_cnt_reg;
  logic [ENV_W-1:0]        env_reg;
  logic [CNT_W-1:0]        state_len;
  logic [ENV_W:0]          env_sum;
  logic [ENV_W-1:0]        env_tick;
  logic [ENV_W-1:0]        env_upd;
  logic [AMP_W+ENV_W-1:0]  amp_prod;
  logic [AMP_W-1:0]        amp_calc;
  logic                    tick;
  logic                    len_zero;
  logic                    advance;
  logic                    pulse_state;
  logic                    busy;
  logic                    emit;

  assign tick = bus.enable && (state_reg != ENV_IDLE) && (count_reg == freq_reg);

  always_comb begin
    state_len = '0;
    case (state_reg)
      ENV_UP, ENV_DOWN: state_len = CNT_W'(bus.ramp);
      ENV_ON:           state_len = CNT_W'(bus.on_time);
      ENV_OFF:          state_len = CNT_W'(bus.off_time);
      default:          state_len = '0;
    endcase
  end

  assign len_zero = (state_len == '0);
  assign advance  = len_zero || (tick && (CNT_W'(len_cnt_reg + 1'b1) == state_len));

  // Envelope value this tick's pulse is scaled by (already stepped).
  always_comb begin
    env_sum  = {1'b0, env_reg} + {2'b00, bus.ramp_factor};
    env_tick = '0;
    case (state_reg)
      ENV_UP:   env_tick = (env_sum > FULL_X) ? ENV_W'(ENV_FULL) : env_sum[ENV_W-1:0];
      ENV_ON:   env_tick = ENV_W'(ENV_FULL);
      ENV_DOWN: env_tick = (env_reg > ENV_W'(bus.ramp_factor))
                           ? env_reg - ENV_W'(bus.ramp_factor) : '0;
      default:  env_tick = '0;
    endcase
  end

  assign env_upd  = (tick && !len_zero && (state_reg inside {ENV_UP, ENV_DOWN}))
                    ? env_tick : env_reg;
  assign amp_prod = (AMP_W+ENV_W)'(bus.amplitude) * (AMP_W+ENV_W)'(env_tick);
  assign amp_calc = AMP_W'(amp_prod >> 8);

  assign pulse_state = state_reg inside {ENV_UP, ENV_ON, ENV_DOWN};
  assign emit = tick && pulse_state && !len_zero && !busy
                && (bus.phase_dur != '0) && (amp_calc != '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= ENV_IDLE;
      count_reg   <= '0;
      freq_reg    <= '0;
      len_cnt_reg <= '0;
      env_reg     <= '0;
    end else if (!bus.enable) begin
      state_reg   <= ENV_IDLE;
      count_reg   <= '0;
      freq_reg    <= bus.freq;
      len_cnt_reg <= '0;
      env_reg     <= '0;
    end else begin
      if ((state_reg == ENV_IDLE) || tick) begin
        count_reg <= '0;
        freq_reg  <= bus.freq;
      end else begin
        count_reg <= count_reg + 1'b1;
      end
      // A tick landing on a transition is credited to the state being left.
      if (advance) begin
        state_reg   <= env_successor(state_reg);
        len_cnt_reg <= '0;
        case (env_successor(state_reg))
          ENV_UP:  env_reg <= '0;
          ENV_ON:  env_reg <= ENV_W'(ENV_FULL);
          ENV_OFF: env_reg <= '0;
          default: env_reg <= env_upd;
        endcase
      end else if (tick) begin
        len_cnt_reg <= len_cnt_reg + 1'b1;
        env_reg     <= env_upd;
      end
    end
  end

  assign bus.env_state = state_reg;

  npg_biphase_seq #(
    .N_ELEC (N_ELEC),
    .PW_W   (PW_W),
    .GAP_W  (GAP_W),
    .AMP_W  (AMP_W)
  ) u_seq (
    .clk           (clk),
    .resetn        (resetn),
    .abort         (!bus.enable),
    .start         (emit),
    .phase_dur     (bus.phase_dur),
    .gap           (bus.gap),
    .amplitude     (amp_calc),
    .electrode1    (bus.electrode1),
    .electrode2    (bus.electrode2),
    .busy          (busy),
    .up_switches   (bus.up_switches),
    .down_switches (bus.down_switches),
    .amp_out       (bus.amp_out),
    .pulse_start   (bus.pulse_start)
  );
endmodule

// File: doc/npg_multich_env.md
# npg_multich_env

Parametrised second-generation neuromuscular pulse generator. It produces charge-balanced biphasic pulses with a programmable interphase gap on an N-electrode H-bridge. A full UP/ON/DOWN/OFF amplitude envelope scales a registered amplitude code on every pulse. It sits between the configuration register bank and the analog current-DAC/switch matrix.

## Interface
- N_ELEC, 4: electrode count, width of the switch vectors
- FREQ_W, 12: period register width
- PW_W, 3: phase-duration width
- GAP_W, 2: interphase-gap width
- AMP_W, 6: amplitude code width
- RAMP_W, 6: ramp length width (pulses)
- ON_W, 8 / OFF_W, 10: ON/OFF length widths (pulses)
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- enable  in  1  run; low forces IDLE
- freq  in  FREQ_W  period minus one, in clk cycles
- phase_dur  in  PW_W  cycles per phase
- gap  in  GAP_W  interphase gap cycles
- amplitude  in  AMP_W  full-scale amplitude
- ramp  in  RAMP_W  pulses in UP and in DOWN
- ramp_factor  in  8  envelope step per pulse (1..255)
- on_time  in  ON_W  pulses in ON
- off_time  in  OFF_W  pulses in OFF
- electrode1, electrode2  in  N_ELEC  anode/cathode one-hot-or-multi select
- up_switches, down_switches  out  N_ELEC  registered H-bridge enables
- amp_out  out  AMP_W  registered DAC code, valid while a pulse is active
- env_state  out  3  envelope FSM state
- pulse_start  out  1  one-cycle strobe coinciding with first phase cycle

## Operation
- Period counter: counts 0..freq while enable is high. tick = (count == freq), giving a period of freq+1 cycles. It clears to 0 on wrap and when enable is low.
- Envelope FSM states: IDLE=000, UP=001, ON=011, DOWN=010, OFF=110.
  - IDLE->UP when enable is high.
  - Each state counts ticks. UP exits to ON after ramp ticks. ON exits to DOWN after on_time. DOWN exits to OFF after ramp. OFF exits to UP after off_time.
  - A programmed length of 0 skips the state: it exits on the next clock and emits no pulse.
- Envelope env: 9 bits, 0..256.
  - Entering UP sets env to 0. Each UP tick adds ramp_factor, saturating at 256.
  - ON: env = 256.
  - Each DOWN tick subtracts ramp_factor, saturating at 0.
  - OFF/IDLE: env = 0.
- Pulse amplitude = (amplitude * env) >> 8, using the env value updated on that tick, truncated to AMP_W.
- Pulse emission: on a tick in UP/ON/DOWN with phase_dur != 0 and computed amplitude != 0.
  - Phase 1: up = electrode1, down = electrode2, for phase_dur cycles.
  - Gap: all zero, for gap cycles (0 allowed).
  - Phase 2: up = electrode2, down = electrode1, for phase_dur cycles.
- Safety:
  - Bits set in both electrode1 and electrode2 are masked to 0 in both vectors.
  - The up and down switch outputs never share an asserted bit.
- Snapshot: phase_dur, gap, amplitude and the electrodes are captured on the emitting tick and held for the whole pulse. freq is captured at the period wrap.
- A tick arriving while a pulse is still active, i.e. 2*phase_dur+gap > freq, starts no new pulse. The envelope counters still advance.

## Timing
- Reset values: all outputs 0; env_state = IDLE; counters 0; env 0.
- The tick at cycle t gives phase 1 at t+1..t+phase_dur. pulse_start and amp_out are valid from t+1.
- The gap follows phase 1, then phase 2. amp_out returns to 0 on the cycle after phase 2 ends.
- enable falling: on the next clock all outputs are 0 and the FSM is in IDLE, even mid-pulse. A partial pulse is acceptable; the abort is immediate.
- Asynchronous reset mid-pulse: outputs clear immediately.
- A state transition and a tick in the same cycle: the tick is counted by the old state.

## Structure
- Package npg_pkg: the env_state encoding constants, ENV_FULL = 256, and the env width of 9.
- Sub-module npg_biphase_seq: period-tick-driven phase1/gap/phase2 sequencer with snapshot registers and electrode masking. The top level holds the period counter, envelope FSM and amplitude multiply.

## Test plan
- Pulse timing:
  - Stimulus: freq=9, phase_dur=2, gap=1, ramp=0, on_time=3, off_time=0, amplitude=40, electrode1=0001, electrode2=0010.
  - Response: every 10 cycles, up=0001/down=0010 for 2 cycles, then 1 all-zero cycle, then up=0010/down=0001 for 2 cycles. amp_out=40.
- Ramp envelope:
  - Stimulus: amplitude=40, ramp=4, ramp_factor=64.
  - Response: UP pulses have amp_out 10, 20, 30, 40. DOWN pulses have 30, 20, 10, then the fourth is suppressed (amp 0). env_state sequence is 001, 011, 010, 110.
- Overlap masking:
  - Stimulus: electrode1=0011, electrode2=0110.
  - Response: phase 1 has up=0001, down=0100. Phase 2 is mirrored.
- Overrun:
  - Stimulus: freq=3, phase_dur=2, gap=1.
  - Response: a pulse is emitted only on every second tick. The ON count still advances on every tick.
- Abort: enable dropped in the middle of phase 1 -> the next cycle has all outputs 0 and env_state=IDLE. Re-enable -> restarts in UP with env 0.
- Reset: resetn asserted mid-gap -> outputs 0 asynchronously. After release and enable, the first pulse appears freq+2 cycles after enable rises.
